// File: rtl/reaction_score_keeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reaction_score_keeper_pkg
// Description : Shared view encodings, BCD constants and small BCD helper
//               functions for the reaction score keeper.
// Revision    : 1.0 - initial release
// ============================================================================
package reaction_score_keeper_pkg;

  // Display view selector encodings
  typedef enum logic [1:0] {
    VIEW_LIVE = 2'b00,
    VIEW_BEST = 2'b01,
    VIEW_HIST = 2'b10,
    VIEW_CNT  = 2'b11
  } view_e;

  localparam logic [15:0] c_BLANK_BCD = 16'hFFFF;  // decoder blanks nibble F
  localparam logic [15:0] c_BCD_SAT   = 16'h9999;  // saturated timer reading
  localparam logic [7:0]  c_CNT_MAX   = 8'h99;     // trial count ceiling (BCD)

  // True when every nibble of a 4-digit word is a legal decimal digit
  function automatic logic bcd_is_valid(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Two-digit BCD increment that holds at 99
  function automatic logic [7:0] bcd2_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == c_CNT_MAX)       r = v;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_score_keeper_if.sv
`default_nettype none
// ============================================================================
// Module      : reaction_score_keeper_if
// Description : Control/data bundle between the timer/front panel and the
//               score keeper.
//   bcd_in   timer digits {d3,d2,d1,d0}      done      timer stop flag
//   clr      sync clear (debounced)          view      display selector
//   hist_idx history entry (0 = newest)      disp_bcd  word to scan driver
//   new_best best-updated pulse              overflow  newest entry is 9999
//   bad_digit sticky malformed-capture flag
//   master : source side (drives inputs)     slave : score keeper side
// Revision    : 1.0 - initial release
// ============================================================================
interface reaction_score_keeper_if #(
  parameter int IDX_W = 2
);
  logic [15:0]      bcd_in;
  logic             done;
  logic             clr;
  logic [1:0]       view;
  logic [IDX_W-1:0] hist_idx;
  logic [15:0]      disp_bcd;
  logic             new_best;
  logic             overflow;
  logic             bad_digit;

  modport master (
    output bcd_in, done, clr, view, hist_idx,
    input  disp_bcd, new_best, overflow, bad_digit
  );

  modport slave (
    input  bcd_in, done, clr, view, hist_idx,
    output disp_bcd, new_best, overflow, bad_digit
  );
endinterface
`default_nettype wire

// File: rtl/reaction_score_keeper_bcd4_lt.sv
`default_nettype none
// ============================================================================
// Module      : bcd4_lt
// Description : Combinational 4-digit BCD a < b comparator.
//   a, b  in  16  {d3,d2,d1,d0} BCD words
//   lt    out 1   a is strictly less than b
// Revision    : 1.0 - initial release
// ============================================================================
module bcd4_lt (
  input  wire logic [15:0] a,
  input  wire logic [15:0] b,
  output logic             lt
);
  // Most-significant differing digit decides; equal words give 0.
  always_comb begin
    lt = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (a[i*4 +: 4] != b[i*4 +: 4]) begin
        lt = (a[i*4 +: 4] < b[i*4 +: 4]);
        break;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/reaction_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : reaction_score_keeper
// Description : Captures frozen reaction times on the rising stop flag, keeps
//               a circular history, the best valid time and a BCD trial
//               count, and drives a selected BCD word to the display.
//   sysclk  in  system clock, rising edge
//   rst_n   in  async active-low reset
//   bus     slave side of reaction_score_keeper_if
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_score_keeper
  import reaction_score_keeper_pkg::*;
#(
  parameter int          HIST_DEPTH = 4,
  parameter int          IDX_W      = 2,
  parameter logic [15:0] BLANK_BCD  = c_BLANK_BCD
) (
  input  wire logic                 sysclk,
  input  wire logic                 rst_n,
  reaction_score_keeper_if.slave    bus
);

  logic             r_done_meta, r_done_s, r_done_q;
  logic [15:0]      r_hist [HIST_DEPTH];
  logic [IDX_W-1:0] r_wr_ptr;
  logic [15:0]      r_best;
  logic             r_has_best;
  logic [7:0]       r_count;
  logic [15:0]      r_disp;
  logic             r_new_best;
  logic             r_overflow;
  logic             r_bad_digit;

  logic             w_cap_evt;
  logic             w_lt;
  logic             w_best_upd;
  logic [IDX_W-1:0] w_rd_idx;
  logic [15:0]      w_disp_nxt;

  // Synchroniser and edge detector keep running through clr.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_meta <= 1'b0;
      r_done_s    <= 1'b0;
      r_done_q    <= 1'b0;
    end else begin
      r_done_meta <= bus.done;
      r_done_s    <= r_done_meta;
      r_done_q    <= r_done_s;
    end
  end

  assign w_cap_evt = r_done_s & ~r_done_q;

  bcd4_lt u_best_cmp (
    .a  (bus.bcd_in),
    .b  (r_best),
    .lt (w_lt)
  );

  // A saturated reading never qualifies as a best time.
  assign w_best_upd = (bus.bcd_in != c_BCD_SAT) && (!r_has_best || w_lt);

  // Newest entry sits one behind the write pointer; power-of-2 depth wraps.
  assign w_rd_idx = r_wr_ptr - IDX_W'(1) - bus.hist_idx;

  always_comb begin
    w_disp_nxt = BLANK_BCD;
    case (view_e'(bus.view))
      VIEW_LIVE: w_disp_nxt = bus.bcd_in;
      VIEW_BEST: w_disp_nxt = r_has_best ? r_best : BLANK_BCD;
      VIEW_HIST: w_disp_nxt = r_hist[w_rd_idx];
      VIEW_CNT:  w_disp_nxt = {8'hFF, r_count};
      default:   w_disp_nxt = BLANK_BCD;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= BLANK_BCD;
      r_wr_ptr    <= '0;
      r_best      <= BLANK_BCD;
      r_has_best  <= 1'b0;
      r_count     <= 8'h00;
      r_disp      <= 16'h0000;
      r_new_best  <= 1'b0;
      r_overflow  <= 1'b0;
      r_bad_digit <= 1'b0;
    end else if (bus.clr) begin
      // Clear wins over a coincident capture; that event is lost.
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= BLANK_BCD;
      r_wr_ptr    <= '0;
      r_best      <= BLANK_BCD;
      r_has_best  <= 1'b0;
      r_count     <= 8'h00;
      r_disp      <= 16'h0000;
      r_new_best  <= 1'b0;
      r_overflow  <= 1'b0;
      r_bad_digit <= 1'b0;
    end else begin
      r_new_best <= 1'b0;
      r_disp     <= w_disp_nxt;
      if (w_cap_evt) begin
        if (!bcd_is_valid(bus.bcd_in)) begin
          r_bad_digit <= 1'b1;
        end else begin
          r_hist[r_wr_ptr] <= bus.bcd_in;
          r_wr_ptr         <= r_wr_ptr + IDX_W'(1);
          r_count          <= bcd2_inc_sat(r_count);
          r_overflow       <= (bus.bcd_in == c_BCD_SAT);
          if (w_best_upd) begin
            r_best     <= bus.bcd_in;
            r_has_best <= 1'b1;
            r_new_best <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.disp_bcd  = r_disp;
  assign bus.new_best  = r_new_best;
  assign bus.overflow  = r_overflow;
  assign bus.bad_digit = r_bad_digit;

endmodule
`default_nettype wire
